// File: rtl/tt_mux_sw_pkg.sv
// tt_mux_sw_pkg: shared types and helpers for the break-before-make switched mux.
//   state_t  : select FSM states (ST_ACTIVE routes data, ST_BLANK drives idle)
//   CNT_W    : blank counter width, wide enough for GAP up to 15
//   clog2    : ceiling log2 used for the select width
//   is_pow2  : power-of-two test used by the elaboration checks
package tt_mux_sw_pkg;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_BLANK  = 1'b1
    } state_t;

    localparam int unsigned CNT_W = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/tt_mux_sw_tree.sv
// tt_mux_sw_tree: purely combinational N_IN:1, W-bit mux tree.
// Built from 4:1 stages consuming two select bits each (LSBs first); a final
// 2:1 stage on the select MSB is added when log2(N_IN) is odd.
// Ports:
//   in_data  : packed inputs, input i at bits [i*W +: W]
//   sel      : selection index
//   out_data : selected input
module tt_mux_sw_tree
    import tt_mux_sw_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    parameter int unsigned W    = 1,
    localparam int unsigned SW  = clog2(N_IN)
) (
    input  logic [N_IN*W-1:0] in_data,
    input  logic [SW-1:0]     sel,
    output logic [W-1:0]      out_data
);

    localparam int unsigned L4  = SW / 2;
    localparam int unsigned ODD = SW % 2;

    // lvl[k] holds the N_IN >> (2*k) survivors after k 4:1 stages; the
    // remaining slots of each row are tied off.
    logic [W-1:0] lvl [L4+1][N_IN];

    for (genvar j = 0; j < N_IN; j++) begin : g_leaf
        assign lvl[0][j] = in_data[j*W +: W];
    end

    for (genvar k = 0; k < L4; k++) begin : g_stage
        localparam int unsigned CNT = N_IN >> (2 * (k + 1));
        for (genvar j = 0; j < N_IN; j++) begin : g_node
            if (j < CNT) begin : g_mux
                assign lvl[k+1][j] = sel[2*k+1]
                    ? (sel[2*k] ? lvl[k][4*j+3] : lvl[k][4*j+2])
                    : (sel[2*k] ? lvl[k][4*j+1] : lvl[k][4*j]);
            end else begin : g_pad
                assign lvl[k+1][j] = '0;
            end
        end
    end

    if (ODD != 0) begin : g_final2
        assign out_data = sel[SW-1] ? lvl[L4][1] : lvl[L4][0];
    end else begin : g_final1
        assign out_data = lvl[L4][0];
    end

endmodule

// File: rtl/tt_mux_sw.sv
// tt_mux_sw: N-way, W-bit switched mux with registered output and
// break-before-make select switching. A real select change forces the output
// to IDLE_VAL for GAP cycles before the new source is routed through.
// Ports:
//   clk          : clock
//   rst_n        : asynchronous active-low reset
//   in_data      : packed inputs, input i at bits [i*W +: W]
//   sel_req      : requested selection
//   sel_req_vld  : request valid
//   sel_req_rdy  : request can be accepted (high in ACTIVE)
//   sel_cur      : currently routed selection
//   out_data     : registered mux output
//   switching    : high while blanking
// Build option:
//   TT_MUX_SW_SYNC_EN : adds a 2-flop synchroniser on every in_data bit
//                       (data latency 3, requires GAP >= 2).
module tt_mux_sw
    import tt_mux_sw_pkg::*;
#(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned W        = 1,
    parameter int unsigned GAP      = 2,
    parameter logic [W-1:0] IDLE_VAL = '0,
    parameter int unsigned RST_SEL  = 0,
    localparam int unsigned SW      = clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN*W-1:0] in_data,
    input  logic [SW-1:0]     sel_req,
    input  logic              sel_req_vld,
    output logic              sel_req_rdy,
    output logic [SW-1:0]     sel_cur,
    output logic [W-1:0]      out_data,
    output logic              switching
);

    localparam logic [SW-1:0]    RST_SEL_V = SW'(RST_SEL);
    localparam logic [CNT_W-1:0] GAP_V     = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (!is_pow2(N_IN) || N_IN < 2 || N_IN > 16) begin : g_bad_n_in
        $error("tt_mux_sw: N_IN must be a power of two in 2..16");
    end
    if (RST_SEL >= N_IN) begin : g_bad_rst_sel
        $error("tt_mux_sw: RST_SEL must be below N_IN");
    end
    if (GAP < 1 || GAP > 15) begin : g_bad_gap
        $error("tt_mux_sw: GAP must be in 1..15");
    end

    logic [N_IN*W-1:0] mux_in;

`ifdef TT_MUX_SW_SYNC_EN
    if (GAP < 2) begin : g_bad_gap_sync
        $error("tt_mux_sw: synchroniser build needs GAP >= 2");
    end

    logic [N_IN*W-1:0] sync_1;
    logic [N_IN*W-1:0] sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= in_data;
            sync_2 <= sync_1;
        end
    end

    assign mux_in = sync_2;
`else
    assign mux_in = in_data;
`endif

    logic [W-1:0] mux_out;

    tt_mux_sw_tree #(
        .N_IN (N_IN),
        .W    (W)
    ) u_tree (
        .in_data  (mux_in),
        .sel      (sel_cur),
        .out_data (mux_out)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [SW-1:0]    sel_q,   sel_d;
    logic [SW-1:0]    pend_q,  pend_d;
    logic [W-1:0]     out_q,   out_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
            sel_q   <= RST_SEL_V;
            pend_q  <= RST_SEL_V;
            out_q   <= IDLE_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        pend_d      = pend_q;
        out_d       = IDLE_VAL;
        sel_req_rdy = 1'b0;
        switching   = 1'b0;

        unique case (state_q)
            ST_ACTIVE: begin
                sel_req_rdy = 1'b1;
                // The accepting edge still routes the old source; blanking
                // starts on the following edge.
                out_d = mux_out;
                if (sel_req_vld && (sel_req != sel_q)) begin
                    pend_d  = sel_req;
                    cnt_d   = GAP_V;
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                switching = 1'b1;
                out_d     = IDLE_VAL;
                if (cnt_q == CNT_ONE) begin
                    sel_d   = pend_q;
                    cnt_d   = '0;
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    assign sel_cur  = sel_q;
    assign out_data = out_q;

endmodule

// File: tb/tb_tt_mux_sw.sv
// tb_tt_mux_sw: self-checking bench for tt_mux_sw (N_IN=4, W=8, GAP=2).
// A behavioural model tracks "blank cycles remaining" and the routed source;
// a compare process checks every output on every falling edge, and the
// directed stimulus adds literal expectations at the key points.
module tb_tt_mux_sw;

    localparam int unsigned N_IN = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned GAP  = 2;
    localparam logic [7:0]  IDLE = 8'h00;
`ifdef TT_MUX_SW_SYNC_EN
    localparam int unsigned LAT  = 3;
`else
    localparam int unsigned LAT  = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_IN*W-1:0] in_data;
    logic [1:0]        sel_req;
    logic              sel_req_vld;
    logic              sel_req_rdy;
    logic [1:0]        sel_cur;
    logic [W-1:0]      out_data;
    logic              switching;

    int checks = 0;
    int errors = 0;

    tt_mux_sw #(
        .N_IN     (N_IN),
        .W        (W),
        .GAP      (GAP),
        .IDLE_VAL (IDLE),
        .RST_SEL  (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .sel_req     (sel_req),
        .sel_req_vld (sel_req_vld),
        .sel_req_rdy (sel_req_rdy),
        .sel_cur     (sel_cur),
        .out_data    (out_data),
        .switching   (switching)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the routed selection, how many blank cycles are
    // still owed, and the value the output register must hold.
    int          m_sel  = 0;
    int          m_pend = 0;
    int          m_left = 0;
    logic [7:0]  m_out  = IDLE;
    logic [31:0] h1     = '0;
    logic [31:0] h2     = '0;
    logic [31:0] src;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sel  = 0;
            m_left = 0;
            m_out  = IDLE;
            h1     = '0;
            h2     = '0;
        end else begin
            src = (LAT == 3) ? h2 : in_data;
            h2  = h1;
            h1  = in_data;
            if (m_left > 0) begin
                m_out  = IDLE;
                m_left = m_left - 1;
                if (m_left == 0) m_sel = m_pend;
            end else begin
                m_out = src[m_sel*8 +: 8];
                if (sel_req_vld && (int'(sel_req) != m_sel)) begin
                    m_pend = int'(sel_req);
                    m_left = GAP;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_out",  out_data,    m_out);
        check("model_sel",  sel_cur,     m_sel);
        check("model_sw",   switching,   m_left > 0);
        check("model_rdy",  sel_req_rdy, m_left == 0);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n       = 1'b1;
        sel_req     = 2'd0;
        sel_req_vld = 1'b0;
        in_data     = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        #1 rst_n = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_out", out_data, 8'h00);
        check("rst_sel", sel_cur, 0);
        check("rst_rdy", sel_req_rdy, 1);
        check("rst_sw",  switching, 0);
        rst_n = 1'b1;
        repeat (LAT) tick();
        check("rel_out", out_data, 8'hAA);
        check("rel_rdy", sel_req_rdy, 1);

        // Data step on input 0: new value appears exactly LAT edges later
        in_data[7:0] = 8'h55;
        for (int i = 1; i <= int'(LAT); i++) begin
            tick();
            check("step_out", out_data, (i < int'(LAT)) ? 8'hAA : 8'h55);
        end
        in_data[7:0] = 8'hAA;
        repeat (LAT) tick();

        // Real switch 0 -> 2
        sel_req = 2'd2; sel_req_vld = 1'b1;
        tick();
        sel_req_vld = 1'b0;
        check("sw_rdy0", sel_req_rdy, 0);
        check("sw_sw0",  switching, 1);
        check("sw_out0", out_data, 8'hAA);
        tick();
        check("sw_out1", out_data, 8'h00);
        check("sw_sw1",  switching, 1);
        tick();
        check("sw_out2", out_data, 8'h00);
        check("sw_sel2", sel_cur, 2);
        check("sw_sw2",  switching, 0);
        tick();
        check("sw_out3", out_data, 8'hCC);

        // No-op switch to the current selection
        sel_req = 2'd2; sel_req_vld = 1'b1;
        tick();
        sel_req_vld = 1'b0;
        check("noop_sw", switching, 0);
        check("noop_out", out_data, 8'hCC);
        repeat (2) begin
            tick();
            check("noop_out", out_data, 8'hCC);
        end

        // Back-to-back: 3 then 1 with vld held high
        sel_req = 2'd3; sel_req_vld = 1'b1;
        tick();
        check("b2b_rdy", sel_req_rdy, 0);
        sel_req = 2'd1;
        n = 0;
        while (!sel_req_rdy && n < 10) begin
            tick();
            n++;
        end
        check("b2b_wait", n, GAP);
        check("b2b_sel3", sel_cur, 3);
        check("b2b_idle", out_data, 8'h00);
        tick();
        sel_req_vld = 1'b0;
        check("b2b_dd",  out_data, 8'hDD);
        check("b2b_sw",  switching, 1);
        repeat (3) tick();
        check("b2b_bb",  out_data, 8'hBB);
        check("b2b_sel1", sel_cur, 1);

        // Random data while routing input 1
        for (int i = 0; i < 8; i++) begin
            in_data = {$urandom, $urandom} >> 0;
            tick();
        end
        in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        repeat (LAT) tick();

        // Back to 0, then reset during the first blank cycle of 0 -> 3
        sel_req = 2'd0; sel_req_vld = 1'b1;
        tick();
        sel_req_vld = 1'b0;
        repeat (GAP + 1) tick();
        check("ret_out", out_data, 8'hAA);
        sel_req = 2'd3; sel_req_vld = 1'b1;
        tick();
        sel_req_vld = 1'b0;
        check("mid_sw", switching, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_out", out_data, 8'h00);
        check("mid_sel", sel_cur, 0);
        check("mid_sw0", switching, 0);
        check("mid_rdy", sel_req_rdy, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (LAT) tick();
        check("post_out", out_data, 8'hAA);
        check("post_sel", sel_cur, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
